iq_stream_packer: RTL and testbench
===================================

Name: iq_stream_packer

Overview:
- Upstream feeder for the AXI FIFO stream peripheral.
- Accepts free-running I/Q sample strobes from the radio datapath, which has no backpressure.
- Packs each I/Q pair into one word {Q,I} and buffers it in a local FIFO.
- Emits an AXI4-Stream master with tlast framing every FRAME_LEN words; on disable, the partial frame is zero-padded. Overflow drops are counted for software visibility.

Parameters:
- SAMPLE_W, 16, width of each I and Q sample; tdata width = 2*SAMPLE_W.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words.
- FRAME_LEN, 256, words per frame; legal range 2..65536.
- OVF_W, 16, width of the saturating overflow counter.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; level-sensitive.
- clr_ovf  in  1  single-cycle pulse; clears ovf_cnt.
- s_sample_valid  in  1  sample strobe; no ready is returned.
- s_sample_i  in  SAMPLE_W  I sample.
- s_sample_q  in  SAMPLE_W  Q sample.
- m_axis_tdata  out  2*SAMPLE_W  {Q,I}; Q occupies the upper half.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of frame.
- ovf_cnt  out  OVF_W  count of dropped samples; saturates at all-ones.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (areset=1 at a clock edge):
  - state=IDLE, FIFO emptied, frame_idx=0.
  - tvalid=0, tlast=0, tdata=0, ovf_cnt=0, fifo_level=0, busy=0.
  - Reset mid-frame discards all buffered data; no tlast is emitted.
- Handshake:
  - Transfer occurs when tvalid&&tready.
  - While tvalid=1 and tready=0, tdata, tlast and tvalid are held stable.
  - tvalid never depends combinationally on tready.
- Capture:
  - In RUN, each s_sample_valid=1 cycle attempts a write of {q,i}.
  - The write is accepted if fifo_level<DEPTH, or if a pop occurs in the same cycle (a write to a full FIFO with a simultaneous pop is legal).
  - Otherwise the sample is dropped and ovf_cnt increments (saturating).
  - If clr_ovf and a drop occur in the same cycle, ovf_cnt becomes 0; clear wins.
  - Strobes are ignored outside RUN.
- Latency: a sample accepted at edge N into an empty FIFO is presented with tvalid=1 after edge N (visible in cycle N+1).
- Framing:
  - frame_idx counts stream handshakes from 0 to FRAME_LEN-1 and wraps.
  - tlast = (frame_idx==FRAME_LEN-1).
- FSM:
  - IDLE:
    - enable=1 -> RUN.
  - RUN:
    - enable=0 -> FLUSH.
  - FLUSH:
    - No capture.
    - Drain the FIFO normally.
    - When the FIFO is empty and frame_idx!=0, present zero padding words (tdata=0, tvalid=1) until the word with tlast has handshaken.
    - When the FIFO is empty and frame_idx==0 -> IDLE.
    - enable reasserting in FLUSH is ignored until IDLE is reached; the earliest re-entry to RUN is the cycle after IDLE.
- Padding is generated only in FLUSH; in RUN, an empty FIFO simply deasserts tvalid.
- fifo_level is updated in the same cycle as push and pop; push and pop together leave it unchanged.

Optional Feature:
- Macro: IQ_PACKER_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1, the captured word is a 2*SAMPLE_W ramp counter instead of {q,i}.
  - The ramp is cleared to 0 on each IDLE->RUN transition.
  - The ramp increments on every s_sample_valid in RUN, including dropped strobes, so gaps in the output reveal drops.
  - Padding words remain 0.
- Undefined: no test_mode port, no ramp logic; data path is always {q,i}.

Test Plan:
- Basic packing:
  - Stimulus: reset; enable=1; one strobe with i=16'h1234, q=16'hABCD; tready=1.
  - Response: tdata=32'hABCD1234 with tvalid one cycle after the strobe edge; fifo_level returns to 0.
- Framing (FRAME_LEN=4):
  - Stimulus: 8 strobes back-to-back; tready=1.
  - Response: tlast=1 on handshakes 4 and 8 only; data order preserved.
- Overflow (FIFO_AW=4):
  - Stimulus: tready=0; 20 strobes.
  - Response: fifo_level=16, ovf_cnt=4. Then pulse clr_ovf -> ovf_cnt=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full; strobe and handshake in the same cycle.
  - Response: sample accepted, fifo_level stays 16, ovf_cnt unchanged.
- Flush padding (FRAME_LEN=8):
  - Stimulus: 3 samples sent; enable=0.
  - Response: 3 data words, then 5 zero words; tlast on the 8th; busy falls after the tlast handshake; state=IDLE.
- Backpressure and reset:
  - Stimulus: random tready toggling; tdata held while tvalid&&!tready; assert areset mid-frame.
  - Response: next cycle tvalid=0, fifo_level=0, ovf_cnt=0, busy=0.
  - With IQ_PACKER_TEST_PATTERN_EN and test_mode=1: output ramp 0,1,2,... with a gap of 4 after the overflow case.

Source files
------------

// File: rtl/iq_stream_packer.sv
// iq_stream_packer: packs free-running I/Q sample strobes into {Q,I} words,
// buffers them in a small register FIFO and emits an AXI4-Stream master with
// tlast framing every FRAME_LEN words. Disabling capture flushes the FIFO and
// zero-pads the partial frame up to its tlast word. Samples that arrive while
// the FIFO is full are dropped and counted in a saturating counter.
//
// Optional build macro: IQ_PACKER_TEST_PATTERN_EN
//   When defined, a test_mode input replaces captured {Q,I} words with a ramp
//   counter that advances on every strobe in RUN (dropped strobes included).
`timescale 1ns/1ps

module iq_stream_packer #(
  parameter int SAMPLE_W  = 16,
  parameter int FIFO_AW   = 4,
  parameter int FRAME_LEN = 256,
  parameter int OVF_W     = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  clr_ovf,
`ifdef IQ_PACKER_TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  input  logic                  s_sample_valid,
  input  logic [SAMPLE_W-1:0]   s_sample_i,
  input  logic [SAMPLE_W-1:0]   s_sample_q,
  output logic [2*SAMPLE_W-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [OVF_W-1:0]      ovf_cnt,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  busy
);

  localparam int DATA_W = 2 * SAMPLE_W;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int IDX_W  = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  localparam logic [FIFO_AW:0] DEPTH_L  = (FIFO_AW+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_next;
  logic [IDX_W-1:0]   frame_idx;
  logic [IDX_W-1:0]   frame_idx_next;

  logic               fifo_empty;
  logic               fifo_full;
  logic               padding;
  logic               handshake;
  logic               pop;
  logic               push;
  logic               drop;
  logic [DATA_W-1:0]  capture_word;

  // The head of the FIFO is presented directly so a word written at one edge
  // is visible right after it; padding only exists in FLUSH once the FIFO is
  // drained and the current frame is still open.
  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == DEPTH_L);
  assign padding       = (state == FLUSH) && fifo_empty && (frame_idx != '0);
  assign m_axis_tvalid = !fifo_empty || padding;
  assign m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr];
  assign m_axis_tlast  = (frame_idx == LAST_IDX);
  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign pop           = handshake && !fifo_empty;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push = (state == RUN) && s_sample_valid && (!fifo_full || pop);
  assign drop = (state == RUN) && s_sample_valid && fifo_full && !pop;

  assign fifo_level = count;
  assign busy       = (state != IDLE);

`ifdef IQ_PACKER_TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp;

  // Ramp restarts on every IDLE->RUN entry and advances on every strobe in RUN,
  // dropped ones included, so output gaps expose overflow drops.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ramp <= '0;
    end else if ((state == IDLE) && enable) begin
      ramp <= '0;
    end else if ((state == RUN) && s_sample_valid) begin
      ramp <= ramp + 1'b1;
    end
  end

  assign capture_word = test_mode ? ramp : {s_sample_q, s_sample_i};
`else
  assign capture_word = {s_sample_q, s_sample_i};
`endif

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Frame position after this edge, wrapping after the tlast handshake.
  always_comb begin
    frame_idx_next = frame_idx;
    if (handshake) begin
      frame_idx_next = (frame_idx == LAST_IDX) ? '0 : frame_idx + 1'b1;
    end
  end

  // Next-state logic; FLUSH leaves as soon as the FIFO and frame both close,
  // so busy drops right after the final tlast handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if ((count_next == '0) && (frame_idx_next == '0)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FIFO storage; contents need no reset because occupancy guards every read.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= capture_word;
    end
  end

  // FIFO pointers and occupancy; reset discards anything buffered.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  // Frame word counter driving tlast.
  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_idx <= '0;
    end else begin
      frame_idx <= frame_idx_next;
    end
  end

  // Saturating drop counter; a clear request beats a simultaneous drop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ovf_cnt <= '0;
    end else if (clr_ovf) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_iq_stream_packer.sv
// Self-checking bench for iq_stream_packer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
`timescale 1ns/1ps

module tb_iq_stream_packer;

  localparam int SW      = 16;
  localparam int AW      = 4;
  localparam int FL      = 8;
  localparam int OW      = 4;
  localparam int DEPTH   = 16;
  localparam int DW      = 32;
  localparam int OVF_MAX = (1 << OW) - 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic          enable;
  logic          clr_ovf;
  logic          s_valid;
  logic [SW-1:0] s_i;
  logic [SW-1:0] s_q;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [OW-1:0] ovf_cnt;
  logic [AW:0]   fifo_level;
  logic          busy;
`ifdef IQ_PACKER_TEST_PATTERN_EN
  logic          test_mode;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of buffered words, mode (0 idle, 1 run, 2 flush),
  // words handshaken in the current frame, drop count and ramp value.
  logic [DW-1:0] mq[$];
  int            m_mode;
  int            m_idx;
  int            m_ovf;
  logic [DW-1:0] m_ramp;

  iq_stream_packer #(
    .SAMPLE_W (SW),
    .FIFO_AW  (AW),
    .FRAME_LEN(FL),
    .OVF_W    (OW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .clr_ovf       (clr_ovf),
`ifdef IQ_PACKER_TEST_PATTERN_EN
    .test_mode     (test_mode),
`endif
    .s_sample_valid(s_valid),
    .s_sample_i    (s_i),
    .s_sample_q    (s_q),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .ovf_cnt       (ovf_cnt),
    .fifo_level    (fifo_level),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  function automatic logic exp_tvalid();
    return (mq.size() > 0) || ((m_mode == 2) && (m_idx != 0));
  endfunction

  function automatic logic [DW-1:0] exp_tdata();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  function automatic logic exp_tlast();
    return (m_idx == FL - 1);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic          hs;
    logic          pop;
    logic          push;
    logic          drop;
    logic [DW-1:0] w;
    if (areset) begin
      mq.delete();
      m_mode = 0;
      m_idx  = 0;
      m_ovf  = 0;
      m_ramp = '0;
      return;
    end
    hs   = exp_tvalid() && tready;
    pop  = hs && (mq.size() > 0);
    push = 1'b0;
    drop = 1'b0;
    if ((m_mode == 1) && s_valid) begin
      if ((mq.size() < DEPTH) || pop) push = 1'b1;
      else drop = 1'b1;
    end
    w = {s_q, s_i};
`ifdef IQ_PACKER_TEST_PATTERN_EN
    if (test_mode) w = m_ramp;
`endif
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(w);
    if (clr_ovf) m_ovf = 0;
    else if (drop && (m_ovf < OVF_MAX)) m_ovf = m_ovf + 1;
    if (hs) m_idx = (m_idx + 1) % FL;
    case (m_mode)
      0: begin
        if (enable) begin
          m_mode = 1;
          m_ramp = '0;
        end
      end
      1: begin
        if (s_valid) m_ramp = m_ramp + 1;
        if (!enable) m_mode = 2;
      end
      default: begin
        if ((mq.size() == 0) && (m_idx == 0)) m_mode = 0;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset  = 1'b1;
    enable  = 1'b0;
    clr_ovf = 1'b0;
    s_valid = 1'b0;
    s_i     = '0;
    s_q     = '0;
    tready  = 1'b0;
    tick();
    areset  = 1'b0;
  endtask

  task automatic test_reset();
    areset  = 1'b1;
    enable  = 1'($urandom);
    clr_ovf = 1'b0;
    s_valid = 1'($urandom);
    s_i     = 16'($urandom);
    s_q     = 16'($urandom);
    tready  = 1'($urandom);
    tick();
    tick();
    areset  = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    tready  = 1'b0;
    checks += 6;
    if (tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid got=%0b exp=0", tvalid); end
    if (tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast got=%0b exp=0", tlast); end
    if (tdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_tdata got=%h exp=0", tdata); end
    if (ovf_cnt !== 4'd0) begin failures++; $display("[TB] FAIL reset_ovf got=%0d exp=0", ovf_cnt); end
    if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", fifo_level); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_basic_packing();
    do_reset();
    enable = 1'b1;
    tready = 1'b1;
    tick();
    s_valid = 1'b1;
    s_i     = 16'h1234;
    s_q     = 16'hABCD;
    tick();
    s_valid = 1'b0;
    checks += 3;
    if (tvalid !== 1'b1) begin failures++; $display("[TB] FAIL basic_tvalid got=%0b exp=1", tvalid); end
    if (tdata !== 32'hABCD1234) begin failures++; $display("[TB] FAIL basic_tdata got=%h exp=abcd1234", tdata); end
    if (fifo_level !== 5'd1) begin failures++; $display("[TB] FAIL basic_level1 got=%0d exp=1", fifo_level); end
    tick();
    checks += 2;
    if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL basic_level0 got=%0d exp=0", fifo_level); end
    if (tvalid !== 1'b0) begin failures++; $display("[TB] FAIL basic_tvalid_drained got=%0b exp=0", tvalid); end
  endtask

  task automatic test_framing();
    logic [DW-1:0] words [16];
    int            n_hs;
    do_reset();
    enable = 1'b1;
    tready = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) words[k] = $urandom;
    n_hs = 0;
    for (int cyc = 0; (cyc < 60) && (n_hs < 16); cyc++) begin
      s_valid = (cyc < 16);
      if (cyc < 16) begin
        s_i = words[cyc][15:0];
        s_q = words[cyc][31:16];
      end
      if (tvalid && tready) begin
        n_hs++;
        checks += 2;
        if (tdata !== words[n_hs-1]) begin
          failures++;
          $display("[TB] FAIL frame_data[%0d] got=%h exp=%h", n_hs, tdata, words[n_hs-1]);
        end
        if (tlast !== ((n_hs % FL) == 0)) begin
          failures++;
          $display("[TB] FAIL frame_tlast[%0d] got=%0b exp=%0b", n_hs, tlast, ((n_hs % FL) == 0));
        end
      end
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (n_hs != 16) begin failures++; $display("[TB] FAIL frame_count got=%0d exp=16", n_hs); end
  endtask

  task automatic test_overflow();
    int n_hs;
    do_reset();
    enable = 1'b1;
    tready = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1;
      s_i     = 16'(k);
      s_q     = 16'(k + 16'h0100);
      tick();
    end
    s_valid = 1'b0;
    checks += 3;
    if (fifo_level !== 5'd16) begin failures++; $display("[TB] FAIL ovf_level got=%0d exp=16", fifo_level); end
    if (ovf_cnt !== 4'd4) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=4", ovf_cnt); end
    if (tdata !== 32'h01000000) begin failures++; $display("[TB] FAIL ovf_head got=%h exp=01000000", tdata); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks += 2;
    if (ovf_cnt !== 4'd0) begin failures++; $display("[TB] FAIL ovf_clear got=%0d exp=0", ovf_cnt); end
    if (fifo_level !== 5'd16) begin failures++; $display("[TB] FAIL ovf_clear_level got=%0d exp=16", fifo_level); end
    // full FIFO, strobe and handshake in the same cycle
    s_valid = 1'b1;
    s_i     = 16'h55AA;
    s_q     = 16'h6677;
    tready  = 1'b1;
    tick();
    s_valid = 1'b0;
    tready  = 1'b0;
    checks += 3;
    if (fifo_level !== 5'd16) begin failures++; $display("[TB] FAIL fullpop_level got=%0d exp=16", fifo_level); end
    if (ovf_cnt !== 4'd0) begin failures++; $display("[TB] FAIL fullpop_ovf got=%0d exp=0", ovf_cnt); end
    if (tdata !== 32'h01010001) begin failures++; $display("[TB] FAIL fullpop_head got=%h exp=01010001", tdata); end
    // saturation of the drop counter
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1;
      tick();
    end
    checks++;
    if (ovf_cnt !== 4'hF) begin failures++; $display("[TB] FAIL ovf_saturate got=%0d exp=15", ovf_cnt); end
    // clear wins over a simultaneous drop
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (ovf_cnt !== 4'd0) begin failures++; $display("[TB] FAIL ovf_clear_wins got=%0d exp=0", ovf_cnt); end
    // drain: the sample written during the full+pop cycle is last
    tready = 1'b1;
    n_hs = 0;
    for (int cyc = 0; (cyc < 40) && (n_hs < 16); cyc++) begin
      if (tvalid && tready) begin
        n_hs++;
        if (n_hs == 16) begin
          checks++;
          if (tdata !== 32'h667755AA) begin failures++; $display("[TB] FAIL fullpop_word got=%h exp=667755aa", tdata); end
        end
      end
      tick();
    end
    checks += 2;
    if (n_hs != 16) begin failures++; $display("[TB] FAIL ovf_drain_count got=%0d exp=16", n_hs); end
    if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL ovf_drain_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_flush_padding();
    logic [DW-1:0] words [3];
    logic [DW-1:0] exp_w;
    int            n_hs;
    logic          done;
    do_reset();
    enable = 1'b1;
    tready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) words[k] = $urandom;
    n_hs = 0;
    done = 1'b0;
    for (int cyc = 0; (cyc < 40) && !done; cyc++) begin
      s_valid = (cyc < 3);
      enable  = (cyc < 3);
      if (cyc < 3) begin
        s_i = words[cyc][15:0];
        s_q = words[cyc][31:16];
      end
      if (tvalid && tready) begin
        n_hs++;
        exp_w = (n_hs <= 3) ? words[n_hs-1] : '0;
        checks += 3;
        if (tdata !== exp_w) begin failures++; $display("[TB] FAIL flush_data[%0d] got=%h exp=%h", n_hs, tdata, exp_w); end
        if (tlast !== (n_hs == FL)) begin failures++; $display("[TB] FAIL flush_tlast[%0d] got=%0b exp=%0b", n_hs, tlast, (n_hs == FL)); end
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL flush_busy[%0d] got=%0b exp=1", n_hs, busy); end
        if (n_hs == FL) done = 1'b1;
      end
      tick();
    end
    s_valid = 1'b0;
    checks += 3;
    if (n_hs != FL) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=%0d", n_hs, FL); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_busy got=%0b exp=0", busy); end
    if (tvalid !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_tvalid got=%0b exp=0", tvalid); end
  endtask

  task automatic test_backpressure_reset();
    logic ok;
    do_reset();
    enable = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      s_valid = ($urandom_range(0, 99) < 60);
      s_i     = 16'($urandom);
      s_q     = 16'($urandom);
      tready  = ($urandom_range(0, 99) < 50);
      clr_ovf = ($urandom_range(0, 99) < 2);
      checks += 4;
      if (tvalid !== exp_tvalid()) begin failures++; $display("[TB] FAIL rand_tvalid cyc=%0d got=%0b exp=%0b", cyc, tvalid, exp_tvalid()); end
      if (fifo_level !== (AW+1)'(mq.size())) begin failures++; $display("[TB] FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, mq.size()); end
      if (ovf_cnt !== OW'(m_ovf)) begin failures++; $display("[TB] FAIL rand_ovf cyc=%0d got=%0d exp=%0d", cyc, ovf_cnt, m_ovf); end
      if (busy !== (m_mode != 0)) begin failures++; $display("[TB] FAIL rand_busy cyc=%0d got=%0b exp=%0b", cyc, busy, (m_mode != 0)); end
      if (exp_tvalid()) begin
        checks += 2;
        if (tdata !== exp_tdata()) begin failures++; $display("[TB] FAIL rand_tdata cyc=%0d got=%h exp=%h", cyc, tdata, exp_tdata()); end
        if (tlast !== exp_tlast()) begin failures++; $display("[TB] FAIL rand_tlast cyc=%0d got=%0b exp=%0b", cyc, tlast, exp_tlast()); end
      end
      tick();
    end
    // steer into a partially sent frame with data buffered, then reset
    clr_ovf = 1'b0;
    enable  = 1'b1;
    ok      = 1'b0;
    for (int cyc = 0; (cyc < 60) && !ok; cyc++) begin
      s_valid = 1'b1;
      s_i     = 16'($urandom);
      s_q     = 16'($urandom);
      tready  = 1'($urandom);
      tick();
      ok = (m_mode == 1) && (m_idx != 0) && (mq.size() > 1);
    end
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL midframe_setup got=%0b exp=1", ok); end
    areset = 1'b1;
    tick();
    areset  = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    checks += 4;
    if (tvalid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_tvalid got=%0b exp=0", tvalid); end
    if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL midreset_level got=%0d exp=0", fifo_level); end
    if (ovf_cnt !== 4'd0) begin failures++; $display("[TB] FAIL midreset_ovf got=%0d exp=0", ovf_cnt); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%0b exp=0", busy); end
  endtask

`ifdef IQ_PACKER_TEST_PATTERN_EN
  task automatic test_ramp();
    int n_hs;
    do_reset();
    test_mode = 1'b1;
    enable    = 1'b1;
    tready    = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    tready  = 1'b1;
    n_hs    = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      s_valid = (cyc >= 20) && (cyc < 22);
      if (tvalid && tready) begin
        checks++;
        if (tdata !== DW'((n_hs < 16) ? n_hs : n_hs + 4)) begin
          failures++;
          $display("[TB] FAIL ramp_word[%0d] got=%0d exp=%0d", n_hs, tdata, (n_hs < 16) ? n_hs : n_hs + 4);
        end
        n_hs++;
      end
      tick();
    end
    s_valid   = 1'b0;
    test_mode = 1'b0;
    checks++;
    if (n_hs != 18) begin failures++; $display("[TB] FAIL ramp_count got=%0d exp=18", n_hs); end
  endtask
`endif

  initial begin
    areset  = 1'b0;
    enable  = 1'b0;
    clr_ovf = 1'b0;
    s_valid = 1'b0;
    s_i     = '0;
    s_q     = '0;
    tready  = 1'b0;
`ifdef IQ_PACKER_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    mq.delete();
    m_mode = 0;
    m_idx  = 0;
    m_ovf  = 0;
    m_ramp = '0;
    test_reset();
    test_basic_packing();
    test_framing();
    test_overflow();
    test_flush_padding();
    test_backpressure_reset();
`ifdef IQ_PACKER_TEST_PATTERN_EN
    test_ramp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
